ps2_rx_frame: RTL and testbench
===============================

Name: ps2_rx_frame

Overview:
- Receive-only PS/2 frame deserializer for the keyboard path. Sits directly upstream of the PS/2 communication/scancode-display stage.
- Takes the raw pin-level PS2_CLK/PS2_DAT inputs and synchronizes and glitch-filters the clock.
- Deframes the 11-bit device-to-host frame (start, 8 data LSB-first, odd parity, stop).
- Presents each good byte with a one-cycle strobe; parity and framing faults are flagged separately.
- Tristate/pin handling stays in the top level; this block only reads the pins.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on both PS/2 inputs (min 2).
- FILTER_LEN, 8, consecutive equal synchronized clock samples required to change the filtered clock level.
- TIMEOUT_CYCLES, 100000, CLOCK_50 cycles (2 ms) allowed between falling edges inside a frame.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz
- resetn  input  1  asynchronous active-low reset
- ps2_clk_in  input  1  raw PS2_CLK pin level
- ps2_dat_in  input  1  raw PS2_DAT pin level
- rx_data  output  8  last correctly received byte
- rx_valid  output  1  one-cycle pulse; rx_data updated this cycle
- rx_parity_err  output  1  one-cycle pulse; frame dropped on parity failure
- rx_frame_err  output  1  one-cycle pulse; frame dropped on bad stop bit or timeout
- busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (async, resetn=0):
  - FSM goes to IDLE.
  - rx_data=0x00; rx_valid, rx_parity_err, rx_frame_err and busy are 0.
  - Synchronizers and filtered clock preset to 1 (bus idle), so release of reset never creates a falling edge.
  - Filter counter, bit counter and timeout counter cleared.
- Input conditioning:
  - Both inputs pass through SYNC_STAGES flops.
  - Filtered clock changes level only after FILTER_LEN consecutive synchronized samples at the new level. Shorter pulses are ignored.
  - fall_edge is registered: high for exactly one cycle when the filtered clock goes 1->0.
  - Data is sampled from the synchronized data on the fall_edge cycle. Data is stable for ~40 us around the edge, so the filter delay is harmless.
- FSM states: IDLE, DATA, PARITY, STOP. It acts only on fall_edge cycles, plus timeout.
  - IDLE: on fall_edge, data=0 -> DATA with bit_cnt=0; data=1 -> stay in IDLE (spurious start bit, no error).
  - DATA: on fall_edge, shift register loads bit at index bit_cnt (LSB first). After bit 7 -> PARITY.
  - PARITY: on fall_edge, capture the parity bit -> STOP.
  - STOP, on fall_edge, -> IDLE with exactly one of:
    - stop=1 and parity OK: rx_data<=shift register, rx_valid pulse.
    - stop=0: rx_frame_err pulse. Framing wins if parity is also bad.
    - stop=1 and parity bad: rx_parity_err pulse.
- Parity rule: parity OK when XOR of the 8 data bits and the parity bit equals 1 (odd parity).
- Timeout:
  - Counter cleared in IDLE and on every fall_edge; otherwise increments while busy.
  - Width is clog2(TIMEOUT_CYCLES+1).
  - On reaching TIMEOUT_CYCLES: rx_frame_err pulse, FSM -> IDLE.
  - If fall_edge and the timeout compare occur in the same cycle, fall_edge wins and the counter restarts.
- Outputs are registered. Strobes are high for exactly one cycle, at most one strobe per frame.
- On errors rx_data holds its previous value.
- Latency: rx_valid asserts SYNC_STAGES+FILTER_LEN+2 cycles after the raw stop-bit falling edge at ps2_clk_in (12 with defaults). The bench checks ±1 cycle.
- Back-to-back frames: a start edge arriving one cycle after STOP->IDLE is accepted.

Decomposition:
- Shared package ps2_pkg:
  - state enum (IDLE/DATA/PARITY/STOP)
  - PS2_DATA_BITS=8, PS2_FRAME_BITS=11
  - odd-parity check function
  - PS/2 special codes: 0xF0 break, 0xE0 extended, 0xAA BAT-OK. These are shared with the downstream decoder.
- One sub-module, ps2_clk_filter:
  - synchronizers, glitch filter and fall_edge generation.
  - Outputs: filtered clock, fall_edge, synchronized data.

Test Plan:
- Frame 0x1C, parity 0, stop 1, bit period 80 us -> one rx_valid, rx_data=0x1C, no error strobes; busy falls with rx_valid.
- Frames 0xF0, 0x1C back-to-back (parity 1, 0) -> two rx_valid pulses, rx_data 0xF0 then 0x1C.
- Frame 0x1C with parity 1 -> one rx_parity_err, no rx_valid, rx_data keeps its prior value. Same with stop=0 -> one rx_frame_err only.
- Clock stops after 5 data bits -> rx_frame_err exactly TIMEOUT_CYCLES cycles after the last fall_edge, busy=0. Then frame 0x29 (parity 0) -> rx_valid, rx_data=0x29.
- Glitch handling:
  - 3-cycle low glitch on ps2_clk_in in IDLE -> no state change, busy stays 0.
  - 3-cycle glitch mid-bit inside a frame -> received byte unaffected.
- Reset asserted after 4 bits of 0x55 -> all outputs 0 immediately. After release, frame 0x55 (parity 1) -> rx_valid, rx_data=0x55, with no spurious strobe at reset release.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receive path.
//   - receiver FSM state encoding
//   - frame geometry (data bits, total frame bits)
//   - odd-parity check helper
//   - special scancodes shared with the downstream decoder
package ps2_pkg;

  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam int unsigned PS2_FRAME_BITS = 11;

  // Special device codes
  localparam logic [PS2_DATA_BITS-1:0] PS2_CODE_BREAK  = 8'hF0;
  localparam logic [PS2_DATA_BITS-1:0] PS2_CODE_EXT    = 8'hE0;
  localparam logic [PS2_DATA_BITS-1:0] PS2_CODE_BAT_OK = 8'hAA;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Odd parity: data bits plus parity bit must contain an odd number of ones
  function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic                     parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: input conditioning for the raw PS/2 pins.
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   i_ps2_clk    raw PS2_CLK pin level
//   i_ps2_dat    raw PS2_DAT pin level
//   o_clk_filt   synchronized, glitch-filtered PS/2 clock level
//   o_fall       one-cycle pulse after the filtered clock goes 1->0
//   o_dat_sync   synchronized PS/2 data level
module ps2_clk_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_dat,
  output logic o_clk_filt,
  output logic o_fall,
  output logic o_dat_sync
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nx;
  logic                   r_filt;
  logic                   r_filt_d;
  logic                   r_fall;
  logic                   w_filt_nx;
  logic                   w_clk_s;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];

  // Count consecutive samples disagreeing with the filtered level; flip on the FILTER_LEN-th
  always_comb begin
    w_cnt_nx  = '0;
    w_filt_nx = r_filt;
    if (w_clk_s != r_filt) begin
      if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
        w_filt_nx = w_clk_s;
      end else begin
        w_cnt_nx = r_cnt + CNT_W'(1);
      end
    end
  end

  // Synchronizers and filter preset to the idle-high bus level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_cnt      <= '0;
      r_filt     <= 1'b1;
      r_filt_d   <= 1'b1;
      r_fall     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_dat};
      r_cnt      <= w_cnt_nx;
      r_filt     <= w_filt_nx;
      r_filt_d   <= r_filt;
      r_fall     <= r_filt_d & ~r_filt;
    end
  end

  assign o_clk_filt = r_filt;
  assign o_fall     = r_fall;
  assign o_dat_sync = r_dat_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: receive-only PS/2 device-to-host frame deserializer.
// Ports:
//   CLOCK_50       system clock (50 MHz)
//   resetn         async active-low reset
//   ps2_clk_in     raw PS2_CLK pin level
//   ps2_dat_in     raw PS2_DAT pin level
//   rx_data        last correctly received byte
//   rx_valid       one-cycle pulse, rx_data updated this cycle
//   rx_parity_err  one-cycle pulse, frame dropped on parity failure
//   rx_frame_err   one-cycle pulse, frame dropped on bad stop bit or timeout
//   busy           high while a frame is in progress
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     ps2_clk_in,
  input  logic                     ps2_dat_in,
  output logic [PS2_DATA_BITS-1:0] rx_data,
  output logic                     rx_valid,
  output logic                     rx_parity_err,
  output logic                     rx_frame_err,
  output logic                     busy
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BIT_W = $clog2(PS2_DATA_BITS);

  logic                     w_clk_filt;
  logic                     w_fall;
  logic                     w_dat;
  logic                     w_fall_ok;
  logic                     w_timeout;

  ps2_state_e               r_state;
  ps2_state_e               w_state_nx;
  logic [BIT_W-1:0]         r_bit_cnt;
  logic [BIT_W-1:0]         w_bit_cnt_nx;
  logic [PS2_DATA_BITS-1:0] r_shift;
  logic [PS2_DATA_BITS-1:0] w_shift_nx;
  logic                     r_par;
  logic                     w_par_nx;
  logic [TO_W-1:0]          r_to_cnt;
  logic [TO_W-1:0]          w_to_cnt_nx;
  logic [PS2_DATA_BITS-1:0] r_data;
  logic [PS2_DATA_BITS-1:0] w_data_nx;
  logic                     r_valid;
  logic                     w_valid_nx;
  logic                     r_perr;
  logic                     w_perr_nx;
  logic                     r_ferr;
  logic                     w_ferr_nx;
  logic                     r_busy;

  ps2_clk_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_clk_filter (
    .clk        (CLOCK_50),
    .rst_n      (resetn),
    .i_ps2_clk  (ps2_clk_in),
    .i_ps2_dat  (ps2_dat_in),
    .o_clk_filt (w_clk_filt),
    .o_fall     (w_fall),
    .o_dat_sync (w_dat)
  );

  // A fall is only honoured while the filtered line still reads low
  assign w_fall_ok = w_fall & ~w_clk_filt;

  // Compare one early so the error registers on the edge the count reaches TIMEOUT_CYCLES
  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Next-state and output logic; fall_edge takes priority over timeout
  always_comb begin
    w_state_nx   = r_state;
    w_bit_cnt_nx = r_bit_cnt;
    w_shift_nx   = r_shift;
    w_par_nx     = r_par;
    w_data_nx    = r_data;
    w_valid_nx   = 1'b0;
    w_perr_nx    = 1'b0;
    w_ferr_nx    = 1'b0;
    w_to_cnt_nx  = (r_state == ST_IDLE) ? '0 : r_to_cnt + TO_W'(1);

    if (w_fall_ok) begin
      w_to_cnt_nx = '0;
      case (r_state)
        ST_IDLE: begin
          // A high start bit is treated as line noise and ignored
          if (!w_dat) begin
            w_state_nx   = ST_DATA;
            w_bit_cnt_nx = '0;
          end
        end
        ST_DATA: begin
          w_shift_nx[r_bit_cnt] = w_dat;
          if (r_bit_cnt == BIT_W'(PS2_DATA_BITS - 1)) begin
            w_state_nx = ST_PARITY;
          end else begin
            w_bit_cnt_nx = r_bit_cnt + BIT_W'(1);
          end
        end
        ST_PARITY: begin
          w_par_nx   = w_dat;
          w_state_nx = ST_STOP;
        end
        ST_STOP: begin
          w_state_nx = ST_IDLE;
          // Framing error takes precedence over parity error
          if (!w_dat) begin
            w_ferr_nx = 1'b1;
          end else if (!ps2_parity_ok(r_shift, r_par)) begin
            w_perr_nx = 1'b1;
          end else begin
            w_data_nx  = r_shift;
            w_valid_nx = 1'b1;
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
        end
      endcase
    end else if ((r_state != ST_IDLE) && w_timeout) begin
      w_state_nx  = ST_IDLE;
      w_ferr_nx   = 1'b1;
      w_to_cnt_nx = '0;
    end
  end

  // State and registered outputs
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_bit_cnt <= w_bit_cnt_nx;
      r_shift   <= w_shift_nx;
      r_par     <= w_par_nx;
      r_to_cnt  <= w_to_cnt_nx;
      r_data    <= w_data_nx;
      r_valid   <= w_valid_nx;
      r_perr    <= w_perr_nx;
      r_ferr    <= w_ferr_nx;
      r_busy    <= (w_state_nx != ST_IDLE);
    end
  end

  assign rx_data       = r_data;
  assign rx_valid      = r_valid;
  assign rx_parity_err = r_perr;
  assign rx_frame_err  = r_ferr;
  assign busy          = r_busy;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame: self-checking bench for ps2_rx_frame.
// Drives pin-level PS/2 frames, records every strobe with its cycle stamp,
// and compares against a table of expected results and a frame-level model.
module tb_ps2_rx_frame;

  localparam int unsigned SYNC = 2;
  localparam int unsigned FILT = 8;
  localparam int unsigned TO   = 3000;
  localparam int          HALF = 30;
  localparam int          LAT  = SYNC + FILT + 2;

  localparam int K_VALID = 1;
  localparam int K_PERR  = 2;
  localparam int K_FERR  = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
    logic       busy;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         kind;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk;
  logic       resetn;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       busy;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         last_fall = 0;
  logic       busy_seen = 1'b0;
  logic [7:0] held;
  ev_t        evq[$];
  vec_t       vecs[9];

  ps2_rx_frame #(
    .SYNC_STAGES    (SYNC),
    .FILTER_LEN     (FILT),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLOCK_50      (clk),
    .resetn        (resetn),
    .ps2_clk_in    (ps2_clk),
    .ps2_dat_in    (ps2_dat),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling system-clock edge
  always @(negedge clk) begin
    ev_t e;
    if (busy) busy_seen = 1'b1;
    e.data = rx_data;
    e.cyc  = cyc;
    e.busy = busy;
    if (rx_valid)      begin e.kind = K_VALID; evq.push_back(e); end
    if (rx_parity_err) begin e.kind = K_PERR;  evq.push_back(e); end
    if (rx_frame_err)  begin e.kind = K_FERR;  evq.push_back(e); end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  // Frame-level reference: stop bit first, then odd parity over data+parity
  function automatic int model_kind(input logic [7:0] d, input logic p, input logic s);
    int ones;
    ones = $countones(d) + int'(p);
    if (!s) return K_FERR;
    if ((ones % 2) == 0) return K_PERR;
    return K_VALID;
  endfunction

  // Send the first nbits of a frame; glitch_bit gets a 3-cycle pulse in each half
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      if (i == glitch_bit) begin
        wait_cyc(10); ps2_clk = 1'b0; wait_cyc(3); ps2_clk = 1'b1; wait_cyc(HALF - 13);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk   = 1'b0;
      last_fall = cyc;
      if (i == glitch_bit) begin
        wait_cyc(10); ps2_clk = 1'b1; wait_cyc(3); ps2_clk = 1'b0; wait_cyc(HALF - 13);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic check_frame(input string name, input int kind, input logic [7:0] dexp);
    ev_t e;
    wait_cyc(10);
    chk($sformatf("%s strobe_count", name), evq.size(), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      chk($sformatf("%s strobe_kind", name), e.kind, kind);
      chk_rng($sformatf("%s latency", name), e.cyc - last_fall, LAT - 1, LAT + 1);
      chk($sformatf("%s busy_at_strobe", name), int'(e.busy), 0);
    end
    chk($sformatf("%s rx_data", name), int'(rx_data), int'(dexp));
    evq.delete();
  endtask

  task automatic chk_outputs_zero(input string name);
    chk($sformatf("%s rx_data", name), int'(rx_data), 0);
    chk($sformatf("%s rx_valid", name), int'(rx_valid), 0);
    chk($sformatf("%s rx_parity_err", name), int'(rx_parity_err), 0);
    chk($sformatf("%s rx_frame_err", name), int'(rx_frame_err), 0);
    chk($sformatf("%s busy", name), int'(busy), 0);
  endtask

  initial begin
    ev_t        e;
    int         lf1;
    int         k;
    int         g;
    logic [7:0] d;
    logic       p;
    logic       s;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, K_VALID, 8'h1C};
    vecs[1] = '{8'hF0, 1'b1, 1'b1, K_VALID, 8'hF0};
    vecs[2] = '{8'h1C, 1'b1, 1'b1, K_PERR,  8'hF0};
    vecs[3] = '{8'h1C, 1'b0, 1'b0, K_FERR,  8'hF0};
    vecs[4] = '{8'h1C, 1'b1, 1'b0, K_FERR,  8'hF0};
    vecs[5] = '{8'hE0, 1'b0, 1'b1, K_VALID, 8'hE0};
    vecs[6] = '{8'hAA, 1'b1, 1'b1, K_VALID, 8'hAA};
    vecs[7] = '{8'h00, 1'b0, 1'b1, K_PERR,  8'hAA};
    vecs[8] = '{8'hFF, 1'b1, 1'b1, K_VALID, 8'hFF};

    resetn  = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_cyc(5);
    chk_outputs_zero("reset");
    resetn = 1'b1;
    wait_cyc(30);
    chk("reset_release strobes", evq.size(), 0);

    // Table-driven single frames
    for (int i = 0; i < 9; i++) begin
      send_bits(mk_frame(vecs[i].data, vecs[i].par, vecs[i].stop), 11, -1);
      check_frame($sformatf("vec%0d", i), vecs[i].kind, vecs[i].exp_data);
      wait_cyc(20);
    end
    held = 8'hFF;

    // Back-to-back frames
    send_bits(mk_frame(8'hF0, 1'b1, 1'b1), 11, -1);
    lf1 = last_fall;
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11, -1);
    wait_cyc(10);
    chk("b2b strobe_count", evq.size(), 2);
    if (evq.size() == 2) begin
      e = evq.pop_front();
      chk("b2b first_kind", e.kind, K_VALID);
      chk("b2b first_data", int'(e.data), 8'hF0);
      chk_rng("b2b first_latency", e.cyc - lf1, LAT - 1, LAT + 1);
      e = evq.pop_front();
      chk("b2b second_kind", e.kind, K_VALID);
      chk("b2b second_data", int'(e.data), 8'h1C);
    end
    evq.delete();
    held = 8'h1C;
    wait_cyc(20);

    // Timeout after 5 data bits
    send_bits(mk_frame(8'h29, 1'b0, 1'b1), 6, -1);
    chk("timeout busy_mid", int'(busy), 1);
    for (int i = 0; i < int'(TO) + 200 && evq.size() == 0; i++) wait_cyc(1);
    chk("timeout strobe_count", evq.size(), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      chk("timeout kind", e.kind, K_FERR);
      chk_rng("timeout delay", e.cyc - last_fall, LAT + int'(TO) - 1, LAT + int'(TO) + 1);
      chk("timeout busy", int'(e.busy), 0);
    end
    wait_cyc(5);
    chk("timeout busy_after", int'(busy), 0);
    chk("timeout rx_data", int'(rx_data), int'(held));
    evq.delete();
    send_bits(mk_frame(8'h29, 1'b0, 1'b1), 11, -1);
    held = 8'h29;
    check_frame("after_timeout", K_VALID, held);
    wait_cyc(20);

    // Short clock glitch while idle
    busy_seen = 1'b0;
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(40);
    chk("idle_glitch busy", int'(busy_seen), 0);
    chk("idle_glitch strobes", evq.size(), 0);

    // Glitches inside a frame
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11, 4);
    held = 8'h1C;
    check_frame("midbit_glitch", K_VALID, held);
    wait_cyc(20);

    // Reset in the middle of a frame
    send_bits(mk_frame(8'h55, 1'b1, 1'b1), 5, -1);
    chk("midreset busy_before", int'(busy), 1);
    resetn = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    held = 8'h00;
    wait_cyc(5);
    evq.delete();
    resetn = 1'b1;
    wait_cyc(40);
    chk("midreset release_strobes", evq.size(), 0);
    send_bits(mk_frame(8'h55, 1'b1, 1'b1), 11, -1);
    held = 8'h55;
    check_frame("after_reset", K_VALID, held);
    wait_cyc(20);

    // Randomized frames against the frame-level model
    for (int i = 0; i < 25; i++) begin
      d = 8'($urandom);
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 7) != 0);
      g = int'($urandom_range(0, 15));
      if (g > 10) g = -1;
      send_bits(mk_frame(d, p, s), 11, g);
      k = model_kind(d, p, s);
      if (k == K_VALID) held = d;
      check_frame($sformatf("rand%0d", i), k, held);
      wait_cyc(int'($urandom_range(0, 40)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
